// File: rtl/mfp_pkg.sv
// Shared MFP constants: timer count, prescale codes and the divisor lookup.
package mfp_pkg;

  localparam int MFP_NUM_TIMERS = 4;

  localparam logic [2:0] PS_STOP   = 3'd0;
  localparam logic [2:0] PS_DIV4   = 3'd1;
  localparam logic [2:0] PS_DIV10  = 3'd2;
  localparam logic [2:0] PS_DIV16  = 3'd3;
  localparam logic [2:0] PS_DIV50  = 3'd4;
  localparam logic [2:0] PS_DIV64  = 3'd5;
  localparam logic [2:0] PS_DIV100 = 3'd6;
  localparam logic [2:0] PS_DIV200 = 3'd7;

  // Terminal phase value for a prescale code; the largest is 199, so 8 bits suffice.
  // A stopped channel never compares against this, so its value is arbitrary.
  function automatic logic [7:0] ps_div_m1(input logic [2:0] code);
    logic [7:0] divMinus1;
    case (code)
      PS_DIV4:   divMinus1 = 8'd3;
      PS_DIV10:  divMinus1 = 8'd9;
      PS_DIV16:  divMinus1 = 8'd15;
      PS_DIV50:  divMinus1 = 8'd49;
      PS_DIV64:  divMinus1 = 8'd63;
      PS_DIV100: divMinus1 = 8'd99;
      PS_DIV200: divMinus1 = 8'd199;
      default:   divMinus1 = 8'd0;
    endcase
    return divMinus1;
  endfunction

endpackage

// File: rtl/mfp_prescaler_ch.sv
// One prescaler channel: holds its code, walks a phase counter and emits a
// single-cycle tick every divisor cycles. A config apply restarts the phase.
module mfp_prescaler_ch
  import mfp_pkg::*;
(
  input  logic       XCLK_I,
  input  logic       RST,
  input  logic       i_apply,
  input  logic [2:0] i_code,
  output logic       o_tick,
  output logic       o_run
);

  logic [2:0] r_code;
  logic [7:0] r_phase;
  logic       r_tick;
  logic [7:0] w_divMinus1;
  logic       w_terminal;

  assign w_divMinus1 = ps_div_m1(r_code);
  assign w_terminal  = (r_code != PS_STOP) && (r_phase == w_divMinus1);

  // Code/phase/tick update; an apply outranks a terminal count so no tick leaks out.
  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      r_code  <= PS_STOP;
      r_phase <= 8'd0;
      r_tick  <= 1'b0;
    end else if (i_apply) begin
      r_code  <= i_code;
      r_phase <= 8'd0;
      r_tick  <= 1'b0;
    end else if (r_code == PS_STOP) begin
      r_phase <= 8'd0;
      r_tick  <= 1'b0;
    end else if (w_terminal) begin
      r_phase <= 8'd0;
      r_tick  <= 1'b1;
    end else begin
      r_phase <= r_phase + 8'd1;
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;
  assign o_run  = (r_code != PS_STOP);

endmodule

// File: rtl/mfp_prescale_sched.sv
// MFP prescaler scheduler: brings CPU-domain config requests into the timer
// clock domain via a toggle handshake and drives one prescaler per channel.
module mfp_prescale_sched
  import mfp_pkg::*;
#(
  parameter int NUM_TIMERS  = MFP_NUM_TIMERS,
  parameter int SYNC_STAGES = 2
)(
  input  logic                  XCLK_I,
  input  logic                  RST,
  input  logic                  CFG_REQ,
  input  logic [1:0]            CFG_SEL,
  input  logic [2:0]            CFG_CTRL,
  output logic                  CFG_ACK,
  output logic [NUM_TIMERS-1:0] TICK,
  output logic [NUM_TIMERS-1:0] RUN
);

  logic [SYNC_STAGES-1:0] r_reqSync;
  logic                   r_ack;
  logic                   w_reqS;
  logic                   w_pending;
  logic [NUM_TIMERS-1:0]  w_apply;

  // Request toggle synchronizer; the last stage is the only one the logic reads.
  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      r_reqSync <= '0;
    end else begin
      r_reqSync <= {r_reqSync[SYNC_STAGES-2:0], CFG_REQ};
    end
  end

  assign w_reqS    = r_reqSync[SYNC_STAGES-1];
  assign w_pending = (w_reqS != r_ack);

  // Acknowledge follows the synchronized request once the payload has been applied.
  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      r_ack <= 1'b0;
    end else if (w_pending) begin
      r_ack <= w_reqS;
    end
  end

  assign CFG_ACK = r_ack;

  // Selects beyond the channel count match no channel and are simply acknowledged.
  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    assign w_apply[g] = w_pending && (int'(CFG_SEL) == g);

    mfp_prescaler_ch u_ch (
      .XCLK_I  (XCLK_I),
      .RST     (RST),
      .i_apply (w_apply[g]),
      .i_code  (CFG_CTRL),
      .o_tick  (TICK[g]),
      .o_run   (RUN[g])
    );
  end

endmodule
